// File: rtl/control_unit.sv
// Multi-cycle accumulator CPU sequencer: fetch/decode/execute with
// per-state memory wait timeout and a sticky bus error.
module control_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] opcode,
  input  logic       start,
  input  logic       stop,
  input  logic       mem_ready,
  output logic       load_IR,
  output logic       load_acc,
  output logic       sel_alu,
  output logic       sel_bus,
  output logic       pass_add,
  output logic       ld_pc,
  output logic       clr_pc,
  output logic       inc_pc,
  output logic       ir_on_adr,
  output logic       pc_on_adr,
  output logic       rd_mem,
  output logic       wr_mem,
  output logic       bus_err,
  output logic [2:0] state_out
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EX_LDA = 3'd3,
    EX_ADD = 3'd4,
    EX_STA = 3'd5,
    ERROR  = 3'd6
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             bus_err_next;
  logic             mem_state;
  logic             timeout;
  logic             boundary;

  // State, wait counter and error flag registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      bus_err  <= bus_err_next;
    end
  end

  assign state_out = state;

  // Next state and datapath controls; completion strobes are Mealy on mem_ready
  always_comb begin
    state_next = state;
    load_IR    = 1'b0;
    load_acc   = 1'b0;
    sel_alu    = 1'b0;
    sel_bus    = 1'b0;
    pass_add   = 1'b0;
    ld_pc      = 1'b0;
    clr_pc     = 1'b0;
    inc_pc     = 1'b0;
    ir_on_adr  = 1'b0;
    pc_on_adr  = 1'b0;
    rd_mem     = 1'b0;
    wr_mem     = 1'b0;
    boundary   = 1'b0;
    mem_state  = (state == FETCH) || (state == EX_LDA) ||
                 (state == EX_ADD) || (state == EX_STA);
    timeout    = mem_state && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));

    case (state)
      IDLE: begin
        clr_pc = 1'b1;
        if (start) state_next = FETCH;
      end
      FETCH: begin
        pc_on_adr = 1'b1;
        rd_mem    = 1'b1;
        sel_bus   = 1'b1;
        if (mem_ready) begin
          load_IR    = 1'b1;
          inc_pc     = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        case (opcode)
          2'b00:   state_next = EX_LDA;
          2'b10:   state_next = EX_ADD;
          2'b01:   state_next = EX_STA;
          default: begin
            ld_pc    = 1'b1;
            boundary = 1'b1;
          end
        endcase
      end
      EX_LDA: begin
        ir_on_adr = 1'b1;
        rd_mem    = 1'b1;
        sel_bus   = 1'b1;
        pass_add  = 1'b1;
        if (mem_ready) begin
          load_acc = 1'b1;
          boundary = 1'b1;
        end
      end
      EX_ADD: begin
        ir_on_adr = 1'b1;
        rd_mem    = 1'b1;
        sel_alu   = 1'b1;
        if (mem_ready) begin
          load_acc = 1'b1;
          boundary = 1'b1;
        end
      end
      EX_STA: begin
        ir_on_adr = 1'b1;
        wr_mem    = 1'b1;
        pass_add  = 1'b1;
        if (mem_ready) boundary = 1'b1;
      end
      ERROR: begin
        if (start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (boundary) state_next = stop ? IDLE : FETCH;
    if (timeout)  state_next = ERROR;

    // Counter restarts on every state change and saturates instead of wrapping
    if ((state_next != state) || !mem_state) begin
      wait_cnt_next = '0;
    end else if (!mem_ready && (wait_cnt != CNT_W'(TIMEOUT))) begin
      wait_cnt_next = wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt_next = wait_cnt;
    end

    bus_err_next = (state_next == ERROR);
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: instruction sequencing, waits, timeout,
// stop handling and reset priority against hand-computed vectors.
module tb_control_unit;

  logic       clock;
  logic       reset;
  logic [1:0] opcode;
  logic       start, stop, mem_ready;
  logic       load_IR, load_acc, sel_alu, sel_bus, pass_add, ld_pc, clr_pc, inc_pc;
  logic       ir_on_adr, pc_on_adr, rd_mem, wr_mem, bus_err;
  logic [2:0] state_out;

  int n_checks = 0;
  int n_fail   = 0;

  control_unit #(.TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .start(start), .stop(stop),
    .mem_ready(mem_ready), .load_IR(load_IR), .load_acc(load_acc),
    .sel_alu(sel_alu), .sel_bus(sel_bus), .pass_add(pass_add), .ld_pc(ld_pc),
    .clr_pc(clr_pc), .inc_pc(inc_pc), .ir_on_adr(ir_on_adr),
    .pc_on_adr(pc_on_adr), .rd_mem(rd_mem), .wr_mem(wr_mem),
    .bus_err(bus_err), .state_out(state_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [12:0] B_LOAD_IR = 13'h1000, B_LOAD_ACC = 13'h0800,
                          B_SEL_ALU = 13'h0400, B_SEL_BUS  = 13'h0200,
                          B_PASS    = 13'h0100, B_LD_PC    = 13'h0080,
                          B_CLR_PC  = 13'h0040, B_INC_PC   = 13'h0020,
                          B_IR_ADR  = 13'h0010, B_PC_ADR   = 13'h0008,
                          B_RD      = 13'h0004, B_WR       = 13'h0002,
                          B_ERR     = 13'h0001;

  localparam logic [12:0] C_IDLE    = B_CLR_PC;
  localparam logic [12:0] C_F_WAIT  = B_PC_ADR | B_RD | B_SEL_BUS;
  localparam logic [12:0] C_F_RDY   = C_F_WAIT | B_LOAD_IR | B_INC_PC;
  localparam logic [12:0] C_DEC     = 13'h0000;
  localparam logic [12:0] C_JMP     = B_LD_PC;
  localparam logic [12:0] C_L_WAIT  = B_IR_ADR | B_RD | B_SEL_BUS | B_PASS;
  localparam logic [12:0] C_L_RDY   = C_L_WAIT | B_LOAD_ACC;
  localparam logic [12:0] C_A_RDY   = B_IR_ADR | B_RD | B_SEL_ALU | B_LOAD_ACC;
  localparam logic [12:0] C_STA     = B_IR_ADR | B_WR | B_PASS;
  localparam logic [12:0] C_ERR     = B_ERR;

  logic [12:0] ctrl;
  assign ctrl = {load_IR, load_acc, sel_alu, sel_bus, pass_add, ld_pc, clr_pc,
                 inc_pc, ir_on_adr, pc_on_adr, rd_mem, wr_mem, bus_err};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply inputs mid-cycle and let combinational outputs settle
  task automatic drive(input logic rst, input logic st, input logic sp,
                       input logic mr, input logic [1:0] op);
    reset = rst; start = st; stop = sp; mem_ready = mr; opcode = op;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_cycle(input string tag, input logic [2:0] st, input logic [12:0] c);
    check({tag, "_state"}, 32'(state_out), 32'(st));
    check({tag, "_ctrl"}, 32'(ctrl), 32'(c));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; mem_ready = 1'b0; opcode = 2'b00;
    tick();
    tick();

    // Reset state
    drive(0, 0, 0, 0, 2'b00);
    expect_cycle("rst", 3'd0, C_IDLE);
    check("rst_cnt", 32'(dut.wait_cnt), 32'd0);

    // LDA with mem_ready tied high: 0,1,2,3,1
    drive(0, 1, 0, 1, 2'b00); expect_cycle("lda_idle", 3'd0, C_IDLE);   tick();
    drive(0, 0, 0, 1, 2'b00); expect_cycle("lda_fetch", 3'd1, C_F_RDY); tick();
    drive(0, 0, 0, 1, 2'b00); expect_cycle("lda_dec", 3'd2, C_DEC);     tick();
    drive(0, 0, 0, 1, 2'b00); expect_cycle("lda_ex", 3'd3, C_L_RDY);    tick();

    // JMP: ld_pc only in DECODE; stop in FETCH must be ignored
    drive(0, 0, 1, 1, 2'b11); expect_cycle("jmp_fetch", 3'd1, C_F_RDY); tick();
    drive(0, 0, 0, 1, 2'b11); expect_cycle("jmp_dec", 3'd2, C_JMP);     tick();

    // STA with three wait cycles in execute
    drive(0, 0, 0, 1, 2'b01); expect_cycle("sta_fetch", 3'd1, C_F_RDY); tick();
    drive(0, 0, 0, 1, 2'b01); expect_cycle("sta_dec", 3'd2, C_DEC);     tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 2'b01); expect_cycle("sta_wait", 3'd5, C_STA);  tick();
    end
    drive(0, 0, 0, 1, 2'b01); expect_cycle("sta_done", 3'd5, C_STA);
    check("sta_cnt", 32'(dut.wait_cnt), 32'd3);
    tick();

    // ADD completing with stop=1 returns to IDLE
    drive(0, 0, 0, 1, 2'b10); expect_cycle("add_fetch", 3'd1, C_F_RDY); tick();
    drive(0, 0, 0, 1, 2'b10); expect_cycle("add_dec", 3'd2, C_DEC);     tick();
    drive(0, 0, 1, 1, 2'b10); expect_cycle("add_ex", 3'd4, C_A_RDY);    tick();
    drive(0, 0, 0, 0, 2'b10); expect_cycle("add_stop", 3'd0, C_IDLE);

    // FETCH timeout after 15 idle memory cycles
    drive(0, 1, 0, 0, 2'b00); tick();
    for (int i = 0; i < 15; i++) begin
      drive(0, 0, 0, 0, 2'b00); expect_cycle("to_wait", 3'd1, C_F_WAIT); tick();
    end
    drive(0, 0, 1, 1, 2'b00); expect_cycle("to_err", 3'd6, C_ERR);      tick();
    drive(0, 1, 0, 0, 2'b00); expect_cycle("err_hold", 3'd6, C_ERR);    tick();
    drive(0, 0, 0, 0, 2'b00); expect_cycle("err_clear", 3'd0, C_IDLE);

    // mem_ready on the 15th cycle completes normally
    drive(0, 1, 0, 0, 2'b00); tick();
    for (int i = 0; i < 14; i++) begin
      drive(0, 0, 0, 0, 2'b00); tick();
    end
    drive(0, 0, 0, 1, 2'b00); expect_cycle("edge_fetch", 3'd1, C_F_RDY); tick();
    drive(0, 0, 0, 1, 2'b00); expect_cycle("edge_dec", 3'd2, C_DEC);    tick();

    // Reset while waiting in EX_LDA
    drive(0, 0, 0, 0, 2'b00); expect_cycle("rw_wait", 3'd3, C_L_WAIT);  tick();
    drive(0, 0, 0, 0, 2'b00); check("rw_cnt", 32'(dut.wait_cnt), 32'd1); tick();
    drive(1, 1, 1, 0, 2'b00); check("rw_no_acc", 32'(load_acc), 32'd0); tick();
    drive(1, 1, 0, 1, 2'b00); expect_cycle("rw_idle", 3'd0, C_IDLE);
    check("rw_cnt0", 32'(dut.wait_cnt), 32'd0);
    tick();
    drive(0, 0, 0, 1, 2'b00); expect_cycle("rst_prio", 3'd0, C_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum consecutive wait cycles in a memory state before a bus error.
REQ-002 SHALL have port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port opcode, input, 2 bits: IR[7:6]. 00=LDA, 01=STA, 10=ADD, 11=JMP.
REQ-005 SHALL have port start, input, 1 bit: leaves IDLE or ERROR.
REQ-006 SHALL have port stop, input, 1 bit: requests a halt at the next instruction boundary.
REQ-007 SHALL have port mem_ready, input, 1 bit: memory completes the current read or write in this cycle.
REQ-008 SHALL have the following datapath controls, each an output of 1 bit: load_IR, load_acc, sel_alu, sel_bus, pass_add, ld_pc, clr_pc, inc_pc, ir_on_adr, pc_on_adr.
REQ-009 SHALL have ports rd_mem and wr_mem, each an output of 1 bit: memory read and write strobes.
REQ-010 SHALL have port bus_err, output, 1 bit: sticky memory-timeout flag.
REQ-011 SHALL have port state_out, output, 3 bits: current state code.

Function
REQ-012 SHALL implement these states and codes: IDLE=0, FETCH=1, DECODE=2, EX_LDA=3, EX_ADD=4, EX_STA=5, ERROR=6. Code 7 is unreachable and SHALL go to IDLE.
REQ-013 Any output not listed for a state SHALL be 0 in that state.
REQ-014 IDLE: clr_pc=1 continuously. start=1 SHALL go to FETCH next cycle; otherwise remain in IDLE.
REQ-015 FETCH: pc_on_adr=1, rd_mem=1, sel_bus=1.
REQ-016 FETCH on a mem_ready=1 cycle: load_IR=1 and inc_pc=1 (Mealy, that cycle only); next state DECODE.
REQ-017 DECODE (exactly 1 cycle): opcode 00 goes to EX_LDA, 10 goes to EX_ADD, 01 goes to EX_STA.
REQ-018 DECODE with opcode 11: ld_pc=1 in DECODE, then go to the boundary transition of REQ-022.
REQ-019 EX_LDA: ir_on_adr=1, rd_mem=1, sel_bus=1, pass_add=1. On mem_ready=1: load_acc=1, then the boundary transition.
REQ-020 EX_ADD: ir_on_adr=1, rd_mem=1, sel_alu=1, pass_add=0. On mem_ready=1: load_acc=1, then the boundary transition.
REQ-021 EX_STA: ir_on_adr=1, wr_mem=1, pass_add=1. On mem_ready=1: the boundary transition.
REQ-022 Boundary transition: if stop=1 in that cycle, go to IDLE; else go to FETCH.
REQ-023 ld_pc, inc_pc and clr_pc SHALL never be asserted together; ld_pc and inc_pc SHALL each be at most 1 cycle per instruction.
REQ-024 Memory states are FETCH, EX_LDA, EX_ADD and EX_STA. A wait counter SHALL clear to 0 on entry to any memory state.
REQ-025 The wait counter SHALL increment on each cycle in a memory state with mem_ready=0.
REQ-026 If mem_ready=0 on the TIMEOUT-th cycle in a memory state, the next state SHALL be ERROR; mem_ready=1 on that cycle completes normally.
REQ-027 Width: the wait counter SHALL be clog2(TIMEOUT+1) bits and SHALL NOT wrap.
REQ-028 ERROR: bus_err=1 and all controls 0. start=1 SHALL go to IDLE, and bus_err SHALL clear on that transition.
REQ-029 Latency with mem_ready tied high:
  - LDA, ADD, STA: 3 cycles each (FETCH, DECODE, EX).
  - JMP: 2 cycles.
REQ-030 stop SHALL be ignored outside boundary transitions; start SHALL be ignored outside IDLE and ERROR.

Reset
REQ-031 reset=1 SHALL force IDLE at the next edge, from any state, including mid-wait in a memory state.
REQ-032 After reset: wait counter=0, bus_err=0, state_out=0, clr_pc=1, and all other outputs 0.
REQ-033 reset SHALL have priority over start, stop and mem_ready in the same cycle.

Verification
REQ-034 Scenario: reset, then start=1 for 1 cycle, mem_ready=1, opcode=00. Required: state_out 0,1,2,3,1.
  - load_IR and inc_pc pulse in cycle 2.
  - load_acc pulses in cycle 4.
REQ-035 Scenario: opcode=11, mem_ready=1. Required: ld_pc=1 only in the DECODE cycle; state_out 1,2,1; no load_acc.
REQ-036 Scenario: opcode=01, mem_ready low for 3 cycles in EX_STA, then high. Required: wr_mem=1 for 4 cycles, then FETCH; bus_err stays 0.
REQ-037 Scenario: FETCH with mem_ready=0 for 15 cycles. Required: state_out=6 on cycle 16, bus_err=1.
  - start=1 then gives IDLE with bus_err=0.
REQ-038 Scenario: stop=1 during the EX_ADD completion cycle. Required: load_acc pulses, then IDLE with clr_pc=1.
REQ-039 Scenario: reset=1 asserted while in EX_LDA waiting. Required: IDLE at the next edge, no load_acc pulse, counter 0.
